// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: RCA_DEFAULT_WIDTH, the operand width used when the adder is
// instantiated without an explicit WIDTH override.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 8;

endpackage : rca_pkg

// File: rtl/full_adder.sv
// One-bit full adder, the ripple stage of the adder chain.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry into this bit
//   s     - sum bit
//   cout  - carry out of this bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;  // propagate: carry-in passes through when exactly one operand bit is set

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry_out, sum} = a + b + carry_in.
// Latency: 1 cycle, one addition per cycle, back-to-back in_valid supported.
// Backpressure: none; results captured only when in_valid, otherwise held.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid            - a, b, carry_in valid this cycle
//   a, b, carry_in      - unsigned operands and carry into bit 0
//   sum, carry_out      - registered result (held while in_valid is low)
//   out_valid           - registered copy of in_valid, marks a fresh result
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  // Carry chain: c[i] enters bit i, c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = carry_in;

  // Each stage waits on the previous stage's carry; this chain is the
  // critical path from a/b/carry_in to the result register D input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             out_valid_q;

  // Result registers only load on valid input; otherwise keep the last result.
  always_comb begin
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    if (in_valid) begin
      sum_d       = s;
      carry_out_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign out_valid = out_valid_q;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed and random checks of ripple_carry_adder at WIDTH = 8, 1 and 32.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
module tb_ripple_carry_adder;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        in_valid;
  logic        carry_in;

  logic [7:0]  a8, b8, sum8;
  logic        co8, ov8;
  logic [0:0]  a1, b1, sum1;
  logic        co1, ov1;
  logic [31:0] a32, b32, sum32;
  logic        co32, ov32;

  int n_total;
  int n_pass;
  int n_fail;

  ripple_carry_adder u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a8), .b(b8), .carry_in(carry_in),
    .sum(sum8), .carry_out(co8), .out_valid(ov8)
  );

  ripple_carry_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .carry_in(carry_in),
    .sum(sum1), .carry_out(co1), .out_valid(ov1)
  );

  ripple_carry_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a32), .b(b32), .carry_in(carry_in),
    .sum(sum32), .carry_out(co32), .out_valid(ov32)
  );

  // Gated clock so the reset phase can be observed with no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the 8-bit instance: sum, carry_out, out_valid.
  task automatic chk8(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    chk({tag, ".sum"}, {56'd0, sum8}, {56'd0, es});
    chk({tag, ".carry_out"}, {63'd0, co8}, {63'd0, ec});
    chk({tag, ".out_valid"}, {63'd0, ov8}, {63'd0, ev});
  endtask

  // Drive one 8-bit vector on the falling edge, then sample after the rising edge.
  task automatic step8(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vv);
    @(negedge clk);
    a8       = va;
    b8       = vb;
    carry_in = vc;
    in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    a8       = 8'($urandom);
    b8       = 8'($urandom);
    a1       = 1'($urandom);
    b1       = 1'($urandom);
    a32      = $urandom;
    b32      = $urandom;
    carry_in = 1'($urandom);
  endtask

  initial begin
    logic [8:0]  e8;
    logic [1:0]  e1;
    logic [32:0] e32;

    n_total  = 0;
    n_pass   = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    carry_in = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a32 = '0; b32 = '0;

    // Reset with no clock edges: outputs must clear from rst_n alone.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      randomize_inputs();
      in_valid = 1'b1;
      #2;
      chk8("reset_noclk", 8'h00, 1'b0, 1'b0);
    end
    chk("reset_noclk.w32", {30'd0, ov32, co32, sum32}, 64'd0);
    chk("reset_noclk.w1", {61'd0, ov1, co1, sum1}, 64'd0);

    // Reset held with clock running and valid traffic.
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk8("reset_clk", 8'h00, 1'b0, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // No-carry patterns.
    step8(8'hAA, 8'h55, 1'b0, 1'b1); chk8("nocarry_aa_55", 8'hFF, 1'b0, 1'b1);
    step8(8'hF0, 8'h0F, 1'b0, 1'b1); chk8("nocarry_f0_0f", 8'hFF, 1'b0, 1'b1);

    // Full ripple through every bit.
    step8(8'hFF, 8'h01, 1'b0, 1'b1); chk8("ripple_ff_01", 8'h00, 1'b1, 1'b1);
    step8(8'h00, 8'h00, 1'b1, 1'b1); chk8("ripple_cin_only", 8'h01, 1'b0, 1'b1);

    // Maximum operands.
    step8(8'hFF, 8'hFF, 1'b1, 1'b1); chk8("max", 8'hFF, 1'b1, 1'b1);

    // Hold: in_valid low keeps the last result, out_valid drops.
    step8(8'h12, 8'h34, 1'b0, 1'b0); chk8("hold_1", 8'hFF, 1'b1, 1'b0);
    step8(8'h00, 8'h00, 1'b0, 1'b0); chk8("hold_2", 8'hFF, 1'b1, 1'b0);

    // Five back-to-back valid cycles.
    step8(8'h01, 8'h02, 1'b0, 1'b1); chk8("b2b_0", 8'h03, 1'b0, 1'b1);
    step8(8'h80, 8'h80, 1'b0, 1'b1); chk8("b2b_1", 8'h00, 1'b1, 1'b1);
    step8(8'h7F, 8'h01, 1'b1, 1'b1); chk8("b2b_2", 8'h81, 1'b0, 1'b1);
    step8(8'hC3, 8'h3C, 1'b1, 1'b1); chk8("b2b_3", 8'h00, 1'b1, 1'b1);
    step8(8'h10, 8'h20, 1'b1, 1'b1); chk8("b2b_4", 8'h31, 1'b0, 1'b1);

    // Reset mid-stream between edges.
    step8(8'h55, 8'h11, 1'b0, 1'b1); chk8("midrst_pre", 8'h66, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk8("midrst_immediate", 8'h00, 1'b0, 1'b0);
    step8(8'h40, 8'h02, 1'b0, 1'b1); chk8("midrst_discard", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1 chk8("midrst_release", 8'h00, 1'b0, 1'b0);

    // Random sweep at all three widths; first vector forces the maximum case.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      randomize_inputs();
      if (i == 0) begin
        a8 = '1; b8 = '1; a1 = '1; b1 = '1; a32 = '1; b32 = '1; carry_in = 1'b1;
      end
      in_valid = 1'b1;
      e8  = {1'b0, a8} + {1'b0, b8} + 9'(carry_in);
      e1  = {1'b0, a1} + {1'b0, b1} + 2'(carry_in);
      e32 = {1'b0, a32} + {1'b0, b32} + 33'(carry_in);
      @(posedge clk);
      #1;
      chk("rand_w8", {54'd0, ov8, co8, sum8}, {54'd0, 1'b1, e8});
      chk("rand_w1", {61'd0, ov1, co1, sum1}, {61'd0, 1'b1, e1});
      chk("rand_w32", {30'd0, ov32, co32, sum32}, {30'd0, 1'b1, e32});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ripple_carry_adder
